reg8_loader: RTL and testbench
==============================

// Module: reg8_loader
// PURPOSE
//  Upstream write sequencer for the 8x8 register file. Accepts a byte stream over a
//  valid/ready handshake and writes it to consecutive registers from a base index,
//  wrapping mod 8. Drives the file's wsel/en/d write port and, optionally, its
//  rsel/q read port for read-back checking. Reports busy, a done pulse and an error flag.
// PARAMETERS
//  DATA_W  8  byte width; equals the register-file data width
//  NREG    8  number of registers; pointer wraps mod NREG
//  SEL_W   4  width of wsel/rsel; MSB is always driven 0
// PORTS
//  clk       in   1       clock
//  clr       in   1       synchronous active-high reset
//  start     in   1       start a load; sampled only in IDLE
//  base      in   3       first register index
//  len       in   4       number of bytes to load, 0..8
//  in_valid  in   1       in_data is valid
//  in_data   in   DATA_W  byte to write
//  in_ready  out  1       loader accepts in_data this cycle
//  wsel      out  SEL_W   register-file write select
//  en        out  1       register-file write enable
//  d         out  DATA_W  register-file write data
//  rsel      out  SEL_W   register-file read select
//  q         in   DATA_W  register-file read data (combinational from rsel)
//  busy      out  1       high in every state except IDLE
//  done      out  1       one-cycle pulse when a load completes
//  err       out  1       error flag; holds until the next accepted start
// BEHAVIOUR
//  Reset: clr=1 at a rising clk -> state IDLE, ptr=0, cnt=0, chk=0. All outputs 0 after that edge.
//  States: IDLE, LOAD, VERIFY (macro only), DONE.
//  IDLE: in_ready=0, en=0, and in_valid is ignored.
//    On start=1, latch ptr=base, cnt=len, chk=0, and clear err.
//    If len=0: go to DONE with err=0 and perform no writes.
//    If len>8: go to DONE with err=1 and perform no writes.
//    Otherwise: go to LOAD.
//  LOAD: in_ready=1.
//    en = in_valid & in_ready, wsel = {1'b0,ptr}, d = in_data (all combinational).
//    The byte is written into the register file at the same edge it is accepted, giving zero
//    added latency; the value is readable via q in the next cycle.
//    On each accept: ptr <= (ptr+1) mod 8, cnt <= cnt-1, chk <= chk ^ in_data.
//    When the last byte is accepted (cnt=1): go to VERIFY if LOADER_VERIFY_EN is defined,
//    else go to DONE.
//    in_valid=0 is a stall: no write, and no state change.
//  DONE: done=1 for exactly one cycle, busy=1, then go to IDLE. err is valid in the same cycle as done.
//  start while busy is ignored, with no restart or queuing.
//  Wrap example: base=6, len=4 writes r6, r7, r0, r1.
//  Reset mid-operation: an abort. The FSM returns to IDLE, no done pulse is issued, and
//    partially written registers keep their contents unless the file's clr is the same net.
//  rsel is 0 outside VERIFY.
// CONFIGURATION
//  LOADER_VERIFY_EN defined: adds the VERIFY state and a read-back checksum.
//    On entry: rptr=base, rcnt=len, and an accumulator acc=0.
//    In VERIFY: in_ready=0. Each cycle: rsel={1'b0,rptr}, acc ^= q, rptr=(rptr+1) mod 8, rcnt--.
//    The read-back takes len cycles.
//    After the last read: err = ((acc^q_last) != chk), then go to DONE.
//    Total done latency is last accept + len + 1 cycles.
//  LOADER_VERIFY_EN undefined: there is no VERIFY state and no read port activity.
//    rsel is tied to 0 and q is unused.
//    err is set only for len>8.
//    done is asserted 1 cycle after the last accept.
// TESTING
//  1. Basic load: start, base=0, len=3, bytes 11,22,33 with in_valid held high.
//     Expect en for 3 cycles with wsel=0,1,2; r0..r2 = 11,22,33; done 1 cycle later
//     (+3 cycles with verify); err=0.
//  2. Wrap: base=6, len=4, bytes A1,A2,A3,A4.
//     Expect r6=A1, r7=A2, r0=A3, r1=A4; wsel[3]=0 throughout.
//  3. Stall: in_valid toggles 1,0,0,1,1 for len=3.
//     Expect writes only on valid cycles; cnt is held while stalled; exactly 3 writes; then done.
//  4. Bounds: len=0 -> done 1 cycle after start, err=0, en never high.
//     len=9 -> done with err=1, en never high.
//  5. Reset and start during a load: clr=1 after 2 of 5 bytes -> IDLE next cycle, no done, busy=0.
//     Separately, start=1 mid-load -> ignored and the load completes normally.
//  6. Verify (macro on): force the file's r2 to a different value during VERIFY of base=0, len=4
//     -> done with err=1. Unforced -> err=0.

Source files
------------

// File: rtl/reg8_loader.sv
// reg8_loader: write sequencer for an 8x8 register file.
// Takes a byte stream over a valid/ready handshake and writes the bytes to
// consecutive registers starting at a base index. The register pointer wraps
// modulo NREG. Reports busy, a one-cycle done pulse and a sticky error flag.
//
// Optional feature macro: LOADER_VERIFY_EN
//   When defined, a VERIFY state reads the loaded registers back through
//   rsel/q and compares their XOR checksum with the checksum of the bytes
//   that were written. A mismatch sets err.
//   When undefined, there is no read-back: rsel is tied to 0 and q is unused.
//
// Ports
//   clk       clock
//   clr       synchronous active-high reset; aborts any load in progress
//   start     start a load; sampled only when idle
//   base      first register index
//   len       number of bytes to load (0..NREG); values above NREG set err
//   in_valid  in_data is valid
//   in_data   byte to write
//   in_ready  loader accepts in_data this cycle (high in LOAD)
//   wsel      register-file write select
//   en        register-file write enable (in_valid & in_ready)
//   d         register-file write data
//   rsel      register-file read select (non-zero only during VERIFY)
//   q         register-file read data, combinational from rsel
//   busy      high in every state except IDLE
//   done      one-cycle pulse when a load completes
//   err       error flag; held until the next accepted start
module reg8_loader #(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned NREG   = 8,
    parameter  int unsigned SEL_W  = 4,
    localparam int unsigned PTR_W  = $clog2(NREG),
    localparam int unsigned CNT_W  = $clog2(NREG + 1)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [PTR_W-1:0]  base,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [SEL_W-1:0]  wsel,
    output logic              en,
    output logic [DATA_W-1:0] d,
    output logic [SEL_W-1:0]  rsel,
    input  logic [DATA_W-1:0] q,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef LOADER_VERIFY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_VERIFY = 2'd2,
        S_DONE   = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd3
    } state_e;
`endif

    // Pointer increment with explicit wrap so non-power-of-two NREG also works.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NREG - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q,   ptr_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               err_q,   err_d;

`ifdef LOADER_VERIFY_EN
    logic [DATA_W-1:0]  chk_q,   chk_d;
    logic [PTR_W-1:0]   rptr_q,  rptr_d;
    logic [CNT_W-1:0]   rcnt_q,  rcnt_d;
    logic [DATA_W-1:0]  acc_q,   acc_d;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
`ifdef LOADER_VERIFY_EN
        chk_d   = chk_q;
        rptr_d  = rptr_q;
        rcnt_d  = rcnt_q;
        acc_d   = acc_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d = base;
                    cnt_d = len;
                    err_d = 1'b0;
`ifdef LOADER_VERIFY_EN
                    // Read-back bookkeeping is armed here and left untouched through LOAD.
                    chk_d  = '0;
                    rptr_d = base;
                    rcnt_d = len;
                    acc_d  = '0;
`endif
                    if (len == '0) begin
                        state_d = S_DONE;
                    end else if (len > CNT_W'(NREG)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                // in_ready is high throughout LOAD, so in_valid alone means accept.
                if (in_valid) begin
                    ptr_d = ptr_inc(ptr_q);
                    cnt_d = cnt_q - CNT_W'(1);
`ifdef LOADER_VERIFY_EN
                    chk_d = chk_q ^ in_data;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_VERIFY;
                    end
`else
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
`endif
                end
            end

`ifdef LOADER_VERIFY_EN
            S_VERIFY: begin
                acc_d  = acc_q ^ q;
                rptr_d = ptr_inc(rptr_q);
                rcnt_d = rcnt_q - CNT_W'(1);
                if (rcnt_q == CNT_W'(1)) begin
                    err_d   = ((acc_q ^ q) != chk_q);
                    state_d = S_DONE;
                end
            end
`endif

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef LOADER_VERIFY_EN
            chk_q   <= '0;
            rptr_q  <= '0;
            rcnt_q  <= '0;
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef LOADER_VERIFY_EN
            chk_q   <= chk_d;
            rptr_q  <= rptr_d;
            rcnt_q  <= rcnt_d;
            acc_q   <= acc_d;
`endif
        end
    end

    // Status outputs decoded from the state register.
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign err  = err_q;

    // Write port: zero-latency pass-through of the accepted byte.
    assign in_ready = (state_q == S_LOAD);
    assign en       = in_ready & in_valid;
    assign wsel     = in_ready ? SEL_W'(ptr_q) : '0;
    assign d        = in_ready ? in_data : '0;

    // Read port: active only during read-back.
`ifdef LOADER_VERIFY_EN
    assign rsel = (state_q == S_VERIFY) ? SEL_W'(rptr_q) : '0;
`else
    logic unused_q_c;
    assign rsel       = '0;
    assign unused_q_c = ^q;
`endif

endmodule

// File: tb/tb_reg8_loader.sv
// tb_reg8_loader: directed bench for reg8_loader with a behavioural 8x8
// register file attached to the wsel/en/d write port and rsel/q read port.
module tb_reg8_loader;

`ifdef LOADER_VERIFY_EN
    localparam int VERIFY_ON = 1;
`else
    localparam int VERIFY_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic [2:0] base;
    logic [3:0] len;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] wsel;
    logic       en;
    logic [7:0] d;
    logic [3:0] rsel;
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic       err;

    int n_run  = 0;
    int n_fail = 0;

    // Register-file model and write counter.
    logic [7:0] rf [8];
    logic       force_r2 = 1'b0;
    logic [7:0] force_val = 8'h00;
    int         en_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (en) begin
            rf[wsel[2:0]] <= d;
            en_cnt <= en_cnt + 1;
        end
    end

    assign q = (force_r2 && rsel[2:0] == 3'd2) ? force_val : rf[rsel[2:0]];

    reg8_loader dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .base     (base),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wsel     (wsel),
        .en       (en),
        .d        (d),
        .rsel     (rsel),
        .q        (q),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    function automatic int vlat(input int l);
        return l * VERIFY_ON;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input logic [2:0] b, input logic [3:0] l);
        start = 1'b1;
        base  = b;
        len   = l;
        #1;
        chk("start_idle_busy", 32'(busy), 0);
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b, input logic v, input int exp_sel);
        in_valid = v;
        in_data  = b;
        #1;
        chk("load_ready", 32'(in_ready), 1);
        chk("load_en", 32'(en), 32'(v));
        chk("load_busy", 32'(busy), 1);
        chk("load_rsel", 32'(rsel), 0);
        if (v) begin
            chk("load_wsel", 32'(wsel), 32'(exp_sel));
            chk("load_d", 32'(d), 32'(b));
        end
        tick();
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input logic exp_err);
        int n = 0;
        in_valid = 1'b0;
        while (done !== 1'b1 && n < 50) begin
            chk({tag, "_wait_ready"}, 32'(in_ready), 0);
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_done_busy"}, 32'(busy), 1);
        chk({tag, "_done_en"}, 32'(en), 0);
        tick();
        chk({tag, "_pulse_end"}, 32'(done), 0);
        chk({tag, "_idle_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int e0;
        int nd;
        clr      = 1'b1;
        start    = 1'b0;
        base     = 3'd0;
        len      = 4'd0;
        in_valid = 1'b1;
        in_data  = 8'hFF;

        // Reset: all outputs low, in_valid ignored.
        tick();
        tick();
        clr = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_en", 32'(en), 0);
        chk("rst_wsel", 32'(wsel), 0);
        chk("rst_d", 32'(d), 0);
        chk("rst_rsel", 32'(rsel), 0);
        tick();
        chk("idle_en_ignored", 32'(en_cnt), 0);
        in_valid = 1'b0;

        // Basic load of three bytes from r0.
        e0 = en_cnt;
        start_load(3'd0, 4'd3);
        feed(8'h11, 1'b1, 0);
        feed(8'h22, 1'b1, 1);
        feed(8'h33, 1'b1, 2);
        wait_done("basic", vlat(3), 1'b0);
        chk("basic_writes", 32'(en_cnt - e0), 3);
        chk("basic_r0", 32'(rf[0]), 'h11);
        chk("basic_r1", 32'(rf[1]), 'h22);
        chk("basic_r2", 32'(rf[2]), 'h33);

        // Wrap from r6 through r1.
        e0 = en_cnt;
        start_load(3'd6, 4'd4);
        feed(8'hA1, 1'b1, 6);
        feed(8'hA2, 1'b1, 7);
        feed(8'hA3, 1'b1, 0);
        feed(8'hA4, 1'b1, 1);
        wait_done("wrap", vlat(4), 1'b0);
        chk("wrap_writes", 32'(en_cnt - e0), 4);
        chk("wrap_r6", 32'(rf[6]), 'hA1);
        chk("wrap_r7", 32'(rf[7]), 'hA2);
        chk("wrap_r0", 32'(rf[0]), 'hA3);
        chk("wrap_r1", 32'(rf[1]), 'hA4);

        // Stall: valid pattern 1,0,0,1,1 for three bytes from r3.
        e0 = en_cnt;
        start_load(3'd3, 4'd3);
        feed(8'hB1, 1'b1, 3);
        feed(8'hEE, 1'b0, 0);
        feed(8'hEE, 1'b0, 0);
        feed(8'hB2, 1'b1, 4);
        feed(8'hB3, 1'b1, 5);
        wait_done("stall", vlat(3), 1'b0);
        chk("stall_writes", 32'(en_cnt - e0), 3);
        chk("stall_r3", 32'(rf[3]), 'hB1);
        chk("stall_r4", 32'(rf[4]), 'hB2);
        chk("stall_r5", 32'(rf[5]), 'hB3);
        chk("stall_r6_untouched", 32'(rf[6]), 'hA1);

        // Bounds: len=0 finishes cleanly, len=9 flags an error; neither writes.
        e0 = en_cnt;
        start_load(3'd2, 4'd0);
        wait_done("len0", 0, 1'b0);
        start_load(3'd2, 4'd9);
        wait_done("len9", 0, 1'b1);
        chk("bounds_writes", 32'(en_cnt - e0), 0);
        tick();
        chk("err_held_idle", 32'(err), 1);

        // Reset after two of five bytes aborts without a done pulse.
        e0 = en_cnt;
        start_load(3'd0, 4'd5);
        chk("start_clears_err", 32'(err), 0);
        feed(8'hC1, 1'b1, 0);
        feed(8'hC2, 1'b1, 1);
        in_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_ready", 32'(in_ready), 0);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) nd++;
            tick();
        end
        chk("abort_no_done", 32'(nd), 0);
        chk("abort_writes", 32'(en_cnt - e0), 2);
        chk("abort_r0", 32'(rf[0]), 'hC1);
        chk("abort_r1", 32'(rf[1]), 'hC2);

        // Start while busy is ignored.
        e0 = en_cnt;
        start_load(3'd4, 4'd3);
        feed(8'hD1, 1'b1, 4);
        start = 1'b1;
        base  = 3'd0;
        len   = 4'd8;
        feed(8'hD2, 1'b1, 5);
        start = 1'b0;
        feed(8'hD3, 1'b1, 6);
        wait_done("midstart", vlat(3), 1'b0);
        chk("midstart_writes", 32'(en_cnt - e0), 3);
        chk("midstart_r4", 32'(rf[4]), 'hD1);
        chk("midstart_r6", 32'(rf[6]), 'hD3);
        chk("midstart_r0_kept", 32'(rf[0]), 'hC1);

`ifdef LOADER_VERIFY_EN
        // Read-back catches a corrupted r2.
        start_load(3'd0, 4'd4);
        feed(8'hE1, 1'b1, 0);
        feed(8'hE2, 1'b1, 1);
        feed(8'hE3, 1'b1, 2);
        feed(8'hE4, 1'b1, 3);
        force_r2  = 1'b1;
        force_val = 8'h00;
        for (int k = 0; k < 4; k++) begin
            chk("verify_rsel", 32'(rsel), 32'(k));
            chk("verify_ready", 32'(in_ready), 0);
            chk("verify_done", 32'(done), 0);
            tick();
        end
        chk("verify_bad_done", 32'(done), 1);
        chk("verify_bad_err", 32'(err), 1);
        force_r2 = 1'b0;
        tick();
        chk("verify_bad_err_held", 32'(err), 1);
        chk("verify_rsel_idle", 32'(rsel), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
